// File: rtl/loop_nest_counter_pkg.sv
// Shared definitions for the nested loop counter: FSM state encoding and
// the helper that locates one level's slice inside a packed index/limit bus.
package loopcnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit offset of level 'level' inside a bus packed as level*width slices.
  function automatic int slice_lsb(input int level, input int width);
    return level * width;
  endfunction

endpackage

// File: rtl/loop_nest_counter_if.sv
// Control/status bundle of the nested loop counter. The master side issues
// start/step/abort and run limits; the slave side (the counter) returns
// the live indices and run status.
interface loop_nest_counter_if #(
  parameter int LEVELS   = 3,
  parameter int BITWIDTH = 10
);

  logic                         LOOPCNT_Start;
  logic [LEVELS*BITWIDTH-1:0]   LOOPCNT_Limits;
  logic                         LOOPCNT_Step;
  logic                         LOOPCNT_Abort;
  logic [LEVELS*BITWIDTH-1:0]   LOOPCNT_Index;
  logic                         LOOPCNT_Valid;
  logic [LEVELS-1:0]            LOOPCNT_Last;
  logic                         LOOPCNT_Busy;
  logic                         LOOPCNT_Done;

  modport master (
    output LOOPCNT_Start, LOOPCNT_Limits, LOOPCNT_Step, LOOPCNT_Abort,
    input  LOOPCNT_Index, LOOPCNT_Valid, LOOPCNT_Last, LOOPCNT_Busy, LOOPCNT_Done
  );

  modport slave (
    input  LOOPCNT_Start, LOOPCNT_Limits, LOOPCNT_Step, LOOPCNT_Abort,
    output LOOPCNT_Index, LOOPCNT_Valid, LOOPCNT_Last, LOOPCNT_Busy, LOOPCNT_Done
  );

endinterface

// File: rtl/loop_level_counter.sv
// One level of the loop nest: counts 0..limit and wraps back to 0 when
// incremented at its limit. The limit is compared by equality, so a limit
// of all ones is reached without ever overflowing the register.
module loop_level_counter #(
  parameter int BITWIDTH = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                inc,
  input  logic [BITWIDTH-1:0] limit,
  output logic [BITWIDTH-1:0] value,
  output logic                at_limit
);

  logic [BITWIDTH-1:0] value_q;
  logic [BITWIDTH-1:0] value_d;

  assign at_limit = (value_q == limit);
  assign value    = value_q;

  // Next index: clear wins, otherwise increment with wrap at the limit.
  always_comb begin
    // NOTE: default assigned first so every path drives value_d and no latch is inferred.
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = at_limit ? '0 : value_q + 1'b1;
    end
  end

  // Index register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignment for state so all registers update from pre-edge values.
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/loop_nest_counter.sv
// LEVELS-deep nested loop index generator (level 0 innermost) with a
// start/step/abort handshake. Limits are captured when a run is accepted,
// so upstream configuration may change while the run is in progress.
module loop_nest_counter
  import loopcnt_pkg::*;
#(
  parameter int LEVELS   = 3,
  parameter int BITWIDTH = 10
) (
  input  logic             LOOPCNT_Clk,
  input  logic             LOOPCNT_Reset,
  loop_nest_counter_if.slave bus
);

  localparam int W = LEVELS * BITWIDTH;

  state_t           state_q;
  state_t           state_d;
  logic [W-1:0]     limits_q;
  logic [W-1:0]     index;
  logic [LEVELS-1:0] at_limit;
  logic [LEVELS-1:0] last_raw;
  logic [LEVELS-1:0] inc;
  logic             accept;
  logic             abort_run;
  logic             step_go;
  logic             clr;

  // A run is accepted only from IDLE; abort beats step inside RUN.
  assign accept    = (state_q == IDLE) && bus.LOOPCNT_Start && !bus.LOOPCNT_Abort;
  assign abort_run = (state_q == RUN)  && bus.LOOPCNT_Abort;
  assign step_go   = (state_q == RUN)  && bus.LOOPCNT_Step && !bus.LOOPCNT_Abort;
  assign clr       = accept || abort_run;

  // Odometer: level 0 steps every accepted step, level i steps when all
  // inner levels sit at their limits. The final step wraps every level to 0.
  for (genvar i = 0; i < LEVELS; i++) begin : g_level
    if (i == 0) begin : g_inner
      assign last_raw[i] = at_limit[i];
      assign inc[i]      = step_go;
    end else begin : g_outer
      assign last_raw[i] = last_raw[i-1] & at_limit[i];
      assign inc[i]      = step_go & last_raw[i-1];
    end

    loop_level_counter #(
      .BITWIDTH (BITWIDTH)
    ) u_level (
      .clk      (LOOPCNT_Clk),
      .reset    (LOOPCNT_Reset),
      .clr      (clr),
      .inc      (inc[i]),
      .limit    (limits_q[slice_lsb(i, BITWIDTH) +: BITWIDTH]),
      .value    (index[slice_lsb(i, BITWIDTH) +: BITWIDTH]),
      .at_limit (at_limit[i])
    );
  end

  // Limit capture on the accepting start edge only.
  always_ff @(posedge LOOPCNT_Clk or posedge LOOPCNT_Reset) begin
    // NOTE: only control registers are reset; these are plain flops, not a memory, so clearing them is cheap.
    if (LOOPCNT_Reset) begin
      limits_q <= '0;
    end else if (accept) begin
      limits_q <= bus.LOOPCNT_Limits;
    end
  end

  // FSM state register.
  always_ff @(posedge LOOPCNT_Clk or posedge LOOPCNT_Reset) begin
    if (LOOPCNT_Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (bus.LOOPCNT_Abort) begin
          state_d = IDLE;
        end else if (bus.LOOPCNT_Step && last_raw[LEVELS-1]) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.LOOPCNT_Index = index;
  assign bus.LOOPCNT_Valid = (state_q == RUN);
  assign bus.LOOPCNT_Busy  = (state_q != IDLE);
  assign bus.LOOPCNT_Done  = (state_q == DONE);
  assign bus.LOOPCNT_Last  = (state_q == RUN) ? last_raw : '0;

endmodule
